// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative L1 cache: single-cycle hits, dirty-victim
// writeback followed by line refill, and saturating hit/miss/writeback statistics.
module cache_control #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  output logic                 mem_resp_o,
  input  logic                 ishit_w1_i,
  input  logic                 ishit_w2_i,
  input  logic                 isdirty_w1_i,
  input  logic                 isdirty_w2_i,
  input  logic                 lru_out_i,
  output logic                 lru_in_o,
  output logic                 load_lru_o,
  output logic                 load_dirty_w1_o,
  output logic                 load_dirty_w2_o,
  output logic                 dirty_in_o,
  output logic                 load_valid_w1_o,
  output logic                 load_valid_w2_o,
  output logic                 load_tag_w1_o,
  output logic                 load_tag_w2_o,
  output logic                 load_datastore_w1_o,
  output logic                 load_datastore_w2_o,
  output logic                 datastore_in_mux_sel_o,
  output logic                 way_sel_o,
  output logic                 pmem_addr_sel_o,
  output logic                 pmem_read_o,
  output logic                 pmem_write_o,
  input  logic                 pmem_resp_i,
  input  logic                 stats_clr_i,
  output logic [CNT_WIDTH-1:0] hit_count_o,
  output logic [CNT_WIDTH-1:0] miss_count_o,
  output logic [CNT_WIDTH-1:0] wb_count_o
);

  typedef enum logic [1:0] {StIdle, StWriteback, StFill} state_e;

  typedef struct packed {
    logic mem_resp;
    logic lru_in;
    logic load_lru;
    logic load_dirty_w1;
    logic load_dirty_w2;
    logic dirty_in;
    logic load_valid_w1;
    logic load_valid_w2;
    logic load_tag_w1;
    logic load_tag_w2;
    logic load_ds_w1;
    logic load_ds_w2;
    logic mux_sel;
    logic way_sel;
    logic addr_sel;
    logic pmem_read;
    logic pmem_write;
  } strobes_t;

  state_e                 state_q, state_d;
  logic                   victim_q, victim_d;
  logic [CNT_WIDTH-1:0]   hit_q, miss_q, wb_q;
  logic                   hit_inc, miss_inc, wb_inc;
  logic                   req, hit, hit_way, victim_dirty;
  strobes_t               st;

  assign req          = mem_read_i | mem_write_i;
  assign hit          = ishit_w1_i | ishit_w2_i;
  assign hit_way      = ~ishit_w1_i;  // way 1 wins when both tags match
  assign victim_dirty = lru_out_i ? isdirty_w2_i : isdirty_w1_i;

  always_comb begin
    st       = '0;
    state_d  = state_q;
    victim_d = victim_q;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    wb_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req && hit) begin
          st.mem_resp = 1'b1;
          st.load_lru = 1'b1;
          st.lru_in   = ~hit_way;
          st.way_sel  = hit_way;
          hit_inc     = 1'b1;
          if (mem_write_i) begin
            st.load_ds_w1    = ~hit_way;
            st.load_ds_w2    = hit_way;
            st.load_dirty_w1 = ~hit_way;
            st.load_dirty_w2 = hit_way;
            st.dirty_in      = 1'b1;
          end
        end else if (req) begin
          victim_d = lru_out_i;
          miss_inc = 1'b1;
          state_d  = victim_dirty ? StWriteback : StFill;
        end
      end
      StWriteback: begin
        st.pmem_write = 1'b1;
        st.addr_sel   = 1'b1;
        st.way_sel    = victim_q;
        if (pmem_resp_i) begin
          wb_inc  = 1'b1;
          state_d = StFill;
        end
      end
      StFill: begin
        st.pmem_read = 1'b1;
        if (pmem_resp_i) begin
          st.load_ds_w1    = ~victim_q;
          st.load_ds_w2    = victim_q;
          st.load_tag_w1   = ~victim_q;
          st.load_tag_w2   = victim_q;
          st.load_valid_w1 = ~victim_q;
          st.load_valid_w2 = victim_q;
          st.load_dirty_w1 = ~victim_q;
          st.load_dirty_w2 = victim_q;
          st.mux_sel       = 1'b1;
          state_d          = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are squashed while reset is asserted so no array write can slip through.
  assign {mem_resp_o, lru_in_o, load_lru_o, load_dirty_w1_o, load_dirty_w2_o, dirty_in_o,
          load_valid_w1_o, load_valid_w2_o, load_tag_w1_o, load_tag_w2_o,
          load_datastore_w1_o, load_datastore_w2_o, datastore_in_mux_sel_o, way_sel_o,
          pmem_addr_sel_o, pmem_read_o, pmem_write_o} = rst_n ? st : '0;

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] c,
                                                input logic inc);
    return (inc && (c != '1)) ? c + 1'b1 : c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      victim_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
      wb_q     <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (stats_clr_i) begin
        hit_q  <= '0;
        miss_q <= '0;
        wb_q   <= '0;
      end else begin
        hit_q  <= bump(hit_q, hit_inc);
        miss_q <= bump(miss_q, miss_inc);
        wb_q   <= bump(wb_q, wb_inc);
      end
    end
  end

  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;
  assign wb_count_o   = wb_q;

endmodule

// File: tb/tb_cache_control.sv
// Randomized bench: acts as the cache datapath and memory, predicting controller strobes
// and counters from a transaction-level model of the tag/valid/dirty/LRU arrays.
module tb_cache_control;

  typedef struct packed {
    logic mem_resp;
    logic lru_in;
    logic load_lru;
    logic load_dirty_w1;
    logic load_dirty_w2;
    logic dirty_in;
    logic load_valid_w1;
    logic load_valid_w2;
    logic load_tag_w1;
    logic load_tag_w2;
    logic load_ds_w1;
    logic load_ds_w2;
    logic mux_sel;
    logic way_sel;
    logic addr_sel;
    logic pmem_read;
    logic pmem_write;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_read_i, mem_write_i, ishit_w1_i, ishit_w2_i, isdirty_w1_i, isdirty_w2_i;
  logic lru_out_i, pmem_resp_i, stats_clr_i;
  wire [16:0] dut_v;
  wire [16:0] sat_v;
  logic [15:0] hit_count, miss_count, wb_count;
  logic [1:0]  hit_c2, miss_c2, wb_c2;

  int n_chk = 0;
  int n_pass = 0;

  // Model of the datapath arrays and expected statistics.
  bit vld[8][2];
  bit dty[8][2];
  int tg[8][2];
  bit lru_m[8];
  int m_hit = 0, m_miss = 0, m_wb = 0;

  always #5 clk = ~clk;

  cache_control u_dut (
    .clk(clk), .rst_n(rst_n), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_resp_o(dut_v[16]), .ishit_w1_i(ishit_w1_i), .ishit_w2_i(ishit_w2_i),
    .isdirty_w1_i(isdirty_w1_i), .isdirty_w2_i(isdirty_w2_i), .lru_out_i(lru_out_i),
    .lru_in_o(dut_v[15]), .load_lru_o(dut_v[14]), .load_dirty_w1_o(dut_v[13]),
    .load_dirty_w2_o(dut_v[12]), .dirty_in_o(dut_v[11]), .load_valid_w1_o(dut_v[10]),
    .load_valid_w2_o(dut_v[9]), .load_tag_w1_o(dut_v[8]), .load_tag_w2_o(dut_v[7]),
    .load_datastore_w1_o(dut_v[6]), .load_datastore_w2_o(dut_v[5]),
    .datastore_in_mux_sel_o(dut_v[4]), .way_sel_o(dut_v[3]), .pmem_addr_sel_o(dut_v[2]),
    .pmem_read_o(dut_v[1]), .pmem_write_o(dut_v[0]), .pmem_resp_i(pmem_resp_i),
    .stats_clr_i(stats_clr_i), .hit_count_o(hit_count), .miss_count_o(miss_count),
    .wb_count_o(wb_count)
  );

  cache_control #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_resp_o(sat_v[16]), .ishit_w1_i(ishit_w1_i), .ishit_w2_i(ishit_w2_i),
    .isdirty_w1_i(isdirty_w1_i), .isdirty_w2_i(isdirty_w2_i), .lru_out_i(lru_out_i),
    .lru_in_o(sat_v[15]), .load_lru_o(sat_v[14]), .load_dirty_w1_o(sat_v[13]),
    .load_dirty_w2_o(sat_v[12]), .dirty_in_o(sat_v[11]), .load_valid_w1_o(sat_v[10]),
    .load_valid_w2_o(sat_v[9]), .load_tag_w1_o(sat_v[8]), .load_tag_w2_o(sat_v[7]),
    .load_datastore_w1_o(sat_v[6]), .load_datastore_w2_o(sat_v[5]),
    .datastore_in_mux_sel_o(sat_v[4]), .way_sel_o(sat_v[3]), .pmem_addr_sel_o(sat_v[2]),
    .pmem_read_o(sat_v[1]), .pmem_write_o(sat_v[0]), .pmem_resp_i(pmem_resp_i),
    .stats_clr_i(stats_clr_i), .hit_count_o(hit_c2), .miss_count_o(miss_c2),
    .wb_count_o(wb_c2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk_outs(input string tag, input outs_t e);
    check(tag, {15'd0, dut_v}, {15'd0, e});
    check({tag, "_w2cnt"}, {15'd0, sat_v}, {15'd0, e});
  endtask

  task automatic chk_cnt();
    check("hit_count", {16'd0, hit_count}, sat(m_hit, 16));
    check("miss_count", {16'd0, miss_count}, sat(m_miss, 16));
    check("wb_count", {16'd0, wb_count}, sat(m_wb, 16));
    check("hit_count_sat", {30'd0, hit_c2}, sat(m_hit, 2));
    check("miss_count_sat", {30'd0, miss_c2}, sat(m_miss, 2));
    check("wb_count_sat", {30'd0, wb_c2}, sat(m_wb, 2));
  endtask

  task automatic drive_dp(input int s, input int t);
    ishit_w1_i   = vld[s][0] && (tg[s][0] == t);
    ishit_w2_i   = vld[s][1] && (tg[s][1] == t);
    isdirty_w1_i = dty[s][0];
    isdirty_w2_i = dty[s][1];
    lru_out_i    = lru_m[s];
  endtask

  task automatic idle_inputs();
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    pmem_resp_i = 1'b0;
    stats_clr_i = 1'b0;
  endtask

  task automatic idle_cycle();
    idle_inputs();
    ishit_w1_i  = 1'($urandom_range(0, 1));
    ishit_w2_i  = 1'($urandom_range(0, 1));
    lru_out_i   = 1'($urandom_range(0, 1));
    pmem_resp_i = 1'($urandom_range(0, 1));  // stray response must be ignored
    @(negedge clk);
    chk_outs("idle", '0);
    @(posedge clk); #1;
    pmem_resp_i = 1'b0;
    chk_cnt();
  endtask

  task automatic hit_cycle(input int s, input int t, input bit wr, input bit both,
                           input bit clr);
    outs_t e;
    bit w;
    drive_dp(s, t);
    w = !ishit_w1_i;
    if (!w && both) ishit_w2_i = 1'b1;
    mem_write_i = wr;
    mem_read_i  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    stats_clr_i = clr;
    e = '0;
    e.mem_resp = 1'b1;
    e.load_lru = 1'b1;
    e.lru_in   = (w == 1'b0);
    e.way_sel  = w;
    if (wr) begin
      e.dirty_in = 1'b1;
      if (w) begin e.load_ds_w2 = 1'b1; e.load_dirty_w2 = 1'b1; end
      else   begin e.load_ds_w1 = 1'b1; e.load_dirty_w1 = 1'b1; end
    end
    @(negedge clk);
    chk_outs(wr ? "write_hit" : "read_hit", e);
    @(posedge clk); #1;
    idle_inputs();
    lru_m[s] = (w == 1'b0);
    if (wr) dty[s][w] = 1'b1;
    if (clr) begin m_hit = 0; m_miss = 0; m_wb = 0; end
    else m_hit++;
    chk_cnt();
  endtask

  task automatic req(input int s, input int t, input bit wr, input int lwb, input int lfill,
                     input bit drop, input bit abort, input bit clr);
    outs_t e;
    bit vic;
    drive_dp(s, t);
    if (ishit_w1_i || ishit_w2_i) begin
      hit_cycle(s, t, wr, $urandom_range(0, 3) == 0, clr);
      return;
    end
    mem_write_i = wr;
    mem_read_i  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    vic = lru_m[s];
    @(negedge clk);
    chk_outs("miss_idle", '0);
    @(posedge clk); #1;
    m_miss++;
    if (dty[s][vic]) begin
      for (int i = 0; i < lwb; i++) begin
        drive_dp(s, t);
        lru_out_i   = 1'($urandom_range(0, 1));
        pmem_resp_i = (i == lwb - 1);
        e = '0;
        e.pmem_write = 1'b1;
        e.addr_sel   = 1'b1;
        e.way_sel    = vic;
        @(negedge clk);
        chk_outs("writeback", e);
        @(posedge clk); #1;
      end
      pmem_resp_i = 1'b0;
      m_wb++;
    end
    if (drop) begin mem_read_i = 1'b0; mem_write_i = 1'b0; end
    for (int i = 0; i < lfill; i++) begin
      drive_dp(s, t);
      lru_out_i   = 1'($urandom_range(0, 1));  // fill must follow the latched victim
      pmem_resp_i = (i == lfill - 1);
      e = '0;
      e.pmem_read = 1'b1;
      if (i == lfill - 1) begin
        e.mux_sel = 1'b1;
        if (vic) begin
          e.load_ds_w2 = 1'b1; e.load_tag_w2 = 1'b1;
          e.load_valid_w2 = 1'b1; e.load_dirty_w2 = 1'b1;
        end else begin
          e.load_ds_w1 = 1'b1; e.load_tag_w1 = 1'b1;
          e.load_valid_w1 = 1'b1; e.load_dirty_w1 = 1'b1;
        end
      end
      @(negedge clk);
      chk_outs("fill", e);
      @(posedge clk); #1;
      if (abort && i == 0) begin
        rst_n       = 1'b0;
        pmem_resp_i = 1'b1;
        ishit_w1_i  = 1'b1;
        #1;
        m_hit = 0; m_miss = 0; m_wb = 0;
        chk_outs("reset_mid_fill", '0);
        chk_cnt();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_inputs();
        idle_cycle();
        return;
      end
    end
    pmem_resp_i = 1'b0;
    vld[s][vic] = 1'b1;
    tg[s][vic]  = t;
    dty[s][vic] = 1'b0;
    chk_cnt();
    if (drop) idle_cycle();
    else hit_cycle(s, t, wr, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    mem_read_i   = 1'b1;
    mem_write_i  = 1'b0;
    ishit_w1_i   = 1'b1;
    ishit_w2_i   = 1'b0;
    isdirty_w1_i = 1'b0;
    isdirty_w2_i = 1'b0;
    lru_out_i    = 1'b0;
    pmem_resp_i  = 1'b1;
    stats_clr_i  = 1'b0;
    #2;
    chk_outs("reset_outs", '0);
    chk_cnt();
    idle_inputs();
    ishit_w1_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    req(3, 1, 1'b0, 1, 4, 1'b0, 1'b0, 1'b0);  // clean read miss into way 1
    req(3, 2, 1'b1, 1, 2, 1'b0, 1'b0, 1'b0);  // miss into way 2, then write hit
    req(3, 2, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0);  // direct write hit way 2
    req(3, 1, 1'b0, 1, 1, 1'b0, 1'b0, 1'b0);  // read hit way 1 -> way 2 is victim
    req(3, 3, 1'b0, 3, 2, 1'b0, 1'b0, 1'b0);  // dirty victim way 2: writeback then fill
    req(3, 3, 1'b0, 1, 1, 1'b0, 1'b0, 1'b1);  // hit with same-cycle stats clear
    req(5, 0, 1'b0, 1, 3, 1'b0, 1'b1, 1'b0);  // reset during fill
    req(6, 1, 1'b1, 1, 2, 1'b1, 1'b0, 1'b0);  // request dropped mid-miss
    idle_cycle();

    for (int n = 0; n < 250; n++) begin
      int r;
      r = $urandom_range(0, 31);
      req($urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          $urandom_range(1, 4), $urandom_range(1, 4), r == 1, 1'b0, r == 2);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
